voxel_projector: RTL
====================

# voxel_projector

Parametrised voxel rasteriser for the 8-bit framebuffer path. Holds a cubic 1-bit voxel grid loaded by a host port and, on a start pulse, projects it orthographically along a selectable axis into the video RAM. Each written byte carries a depth shade taken from the nearest occupied voxel. RAM writes are issued only while `display_on` is low, so they never collide with scan-out.

## Interface
- `DIM_BITS`, default 3: log2 of the grid edge, N = 2^DIM_BITS per axis; legal range 1..8.
- `ADDR_W`, default 12: framebuffer address width.
- `FB_STRIDE_BITS`, default 5: log2 of the framebuffer row stride in bytes; must be >= DIM_BITS.
- `BASE_ADDR`, default 0: framebuffer address of projected pixel (0,0).
- `clk`  input  1  single system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset; asserted at 0.
- `display_on`  input  1  high during active video; RAM writes are withheld while it is high.
- `start`  input  1  one-cycle request to begin a projection pass.
- `axis`  input  2  projection axis, sampled with `start`: 0 = view along z, 1 = along y, 2 = along x, 3 = treated as 0.
- `vox_we`  input  1  voxel load strobe.
- `vox_addr`  input  3*DIM_BITS  voxel index {x,y,z}, with x in the MSBs.
- `vox_d`  input  1  voxel value to load.
- `busy`  output  1  high from the first SCAN cycle through the last WRITE cycle.
- `done`  output  1  one-cycle pulse after the final pixel is written.
- `we`  output  reg 1  framebuffer write enable.
- `addr`  output  reg ADDR_W  framebuffer write address.
- `ram_d`  output  reg 8  framebuffer write data.

## Operation
- Storage: N^3 bits. All bits are cleared by reset. Reads are combinational by index.
- Load port: `vox_we`=1 writes `vox_d` into `voxels[vox_addr]` at the clock edge. The write is accepted in IDLE only; it is ignored in SCAN, WRITE and DONE.
- Axis mapping (u = column, v = row, d = depth, d=0 is nearest):
  - axis 0: u=x, v=y, d=z.
  - axis 1: u=x, v=z, d=y.
  - axis 2: u=y, v=z, d=x.
- Pixel order: u is the inner loop and v the outer loop, both 0..N-1.
- FSM states: IDLE, SCAN, WRITE, DONE.
  - IDLE: `start`=1 latches `axis`, clears u/v/d and enters SCAN. `start` is ignored in any other state.
  - SCAN: examines one voxel per cycle at (u,v,d).
    - If the voxel is occupied, latch hit=1 with depth d and go to WRITE.
    - Else if d=N-1, latch hit=0 and go to WRITE.
    - Else d increments.
  - WRITE: while `display_on`=1, hold with `we`=0 (stall). When `display_on`=0, assert `we`=1 for exactly one cycle, then:
    - if u=N-1 and v=N-1, go to DONE;
    - otherwise advance u (wrapping to 0 and incrementing v), clear d and return to SCAN.
  - DONE: `done`=1 for one cycle, then IDLE.
- Address: `addr` = BASE_ADDR + (v << FB_STRIDE_BITS) + u, taken modulo 2^ADDR_W (wraps silently).
- Data:
  - on a hit, `ram_d` = 8'hFF − (d << (8−DIM_BITS)), 8-bit;
  - on a miss, `ram_d` = 8'h00 (background).
- `addr` and `ram_d` hold their last value when `we`=0.

## Timing
- Reset values: `we`=0, `addr`=0, `ram_d`=0, `busy`=0, `done`=0, state IDLE, all voxels 0. Reset mid-pass aborts immediately; no further writes are issued.
- `start` is sampled at edge k; SCAN is active and `busy`=1 from cycle k+1.
- Per-pixel latency with no stall: d_hit+2 cycles, where a miss counts as d_hit=N−1, giving N+1 cycles. Each stall cycle adds one cycle.
- An empty grid with `display_on`=0 throughout takes N²·(N+1) busy cycles; `done` is high in the following cycle.
- Simultaneous `start` and `vox_we` in IDLE: the write lands at the same edge, so the pass sees the new value.
- Exactly N² writes are issued per pass; each is a single-cycle `we` pulse.

## Test plan
- Empty grid, N=8, axis 0, `display_on`=0 → 64 writes, all `ram_d`=00, addrs 0..7, 32..39, …, 224..231; `done` pulses 576 cycles after `busy` rises.
- Single voxel (x=2,y=3,z=5), axis 0 → pixel addr 98 gets `ram_d`=8'h5F; all other writes are 00.
- Same voxel, axis 2 → pixel (u=3,v=5), addr 163, `ram_d`=8'hBF. With axis 1 → addr 162, `ram_d`=8'h9F.
- Voxels at z=1 and z=6 on the same column, axis 0 → the nearer one wins: `ram_d`=8'hDF; the column takes 3 cycles.
- `display_on` held high for 10 cycles while in WRITE → `we` stays 0 and `addr`/`ram_d` are stable; the write occurs on the first low cycle and total busy time grows by 10.
- `start` and `vox_we` pulsed mid-pass → both ignored and the image is unchanged. Reset asserted mid-pass → all outputs 0 next cycle, no `done` pulse, and the voxel grid is cleared.

Source files
------------

// File: rtl/voxel_projector.sv
// voxel_projector: holds a 1-bit voxel cube loaded by a host port and projects
// it orthographically along x, y or z into an 8-bit framebuffer. The depth of
// the nearest occupied voxel sets each pixel's shade. Writes only happen
// while display_on is low.
//
// state   | meaning
// S_IDLE  | waiting for start; host voxel loads accepted
// S_SCAN  | walking depth d for the current pixel (u,v), one voxel per cycle
// S_WRITE | pixel result ready; waits for display_on low, then writes once
// S_DONE  | one-cycle done pulse, back to S_IDLE
module voxel_projector #(
  parameter int DIM_BITS       = 3,
  parameter int ADDR_W         = 12,
  parameter int FB_STRIDE_BITS = 5,
  parameter int BASE_ADDR      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  display_on,
  input  logic                  start,
  input  logic [1:0]            axis,
  input  logic                  vox_we,
  input  logic [3*DIM_BITS-1:0] vox_addr,
  input  logic                  vox_d,
  output logic                  busy,
  output logic                  done,
  output logic                  we,
  output logic [ADDR_W-1:0]     addr,
  output logic [7:0]            ram_d
);
  localparam int NVOX = 1 << (3*DIM_BITS);
  localparam logic [DIM_BITS-1:0] LAST = {DIM_BITS{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;
  state_t r_state, w_next;

  logic [NVOX-1:0]       r_vox;
  logic [1:0]            r_axis;
  logic [DIM_BITS-1:0]   r_u, r_v, r_d, r_hd;
  logic                  r_hit;
  logic [ADDR_W-1:0]     r_addr;
  logic [7:0]            r_ram_d;
  logic [3*DIM_BITS-1:0] w_idx;
  logic                  w_occ, w_we, w_last_px;
  logic [ADDR_W-1:0]     w_addr;
  logic [7:0]            w_shade, w_data;

  // Map (u,v,d) back to the {x,y,z} storage index for the latched axis
  always_comb begin
    w_idx = {r_u, r_v, r_d};
    case (r_axis)
      2'd1:    w_idx = {r_u, r_d, r_v};
      2'd2:    w_idx = {r_d, r_u, r_v};
      default: w_idx = {r_u, r_v, r_d};
    endcase
  end

  assign w_occ     = r_vox[w_idx];
  assign w_last_px = (r_u == LAST) && (r_v == LAST);
  assign w_we      = (r_state == S_WRITE) && !display_on;
  assign w_addr    = ADDR_W'(BASE_ADDR) + (ADDR_W'(r_v) << FB_STRIDE_BITS) + ADDR_W'(r_u);
  assign w_shade   = 8'hFF - (8'(r_hd) << (8 - DIM_BITS));
  assign w_data    = r_hit ? w_shade : 8'h00;

  assign busy  = (r_state == S_SCAN) || (r_state == S_WRITE);
  assign done  = (r_state == S_DONE);
  assign we    = w_we;
  // Outside a write pulse the bus keeps showing the last written pixel
  assign addr  = w_we ? w_addr : r_addr;
  assign ram_d = w_we ? w_data : r_ram_d;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SCAN;
      S_SCAN:  if (w_occ || (r_d == LAST)) w_next = S_WRITE;
      S_WRITE: if (!display_on) w_next = w_last_px ? S_DONE : S_SCAN;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pixel walk, depth search and hit capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_axis <= 2'd0;
      r_u    <= '0;
      r_v    <= '0;
      r_d    <= '0;
      r_hd   <= '0;
      r_hit  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_axis <= (axis == 2'd3) ? 2'd0 : axis;
          r_u    <= '0;
          r_v    <= '0;
          r_d    <= '0;
        end
        S_SCAN: begin
          if (w_occ) begin
            r_hit <= 1'b1;
            r_hd  <= r_d;
          end else if (r_d == LAST) begin
            r_hit <= 1'b0;
          end else begin
            r_d <= r_d + DIM_BITS'(1);
          end
        end
        S_WRITE: if (!display_on && !w_last_px) begin
          r_d <= '0;
          r_u <= r_u + DIM_BITS'(1);
          if (r_u == LAST) r_v <= r_v + DIM_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  // Remember the last written pixel so the bus holds between pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_ram_d <= 8'h00;
    end else if (w_we) begin
      r_addr  <= w_addr;
      r_ram_d <= w_data;
    end
  end

  // Voxel storage; host writes only land while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              r_vox <= '0;
    else if ((r_state == S_IDLE) && vox_we)  r_vox[vox_addr] <= vox_d;
  end
endmodule
